// File: rtl/sat_accum.sv
// sat_accum: multi-channel accumulator with per-op overflow detection, optional saturation and sticky flags
module sat_accum #(
  parameter int W = 16,
  parameter int LGNCH = 2,
  parameter int OPT_SATURATE = 1,
  parameter int OPT_SIGNED = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_stb,
  input  logic [LGNCH-1:0]        i_chan,
  input  logic [2:0]              i_op,
  input  logic [W-1:0]            i_val,
  output logic                    o_valid,
  output logic [LGNCH-1:0]        o_chan,
  output logic [W-1:0]            o_acc,
  output logic                    o_ovfl,
  output logic [(1<<LGNCH)-1:0]   o_sticky
);
  localparam int NCH = 1 << LGNCH;
  logic [W-1:0] acc_q [NCH];
  logic [W-1:0] acc_d [NCH];
  logic [NCH-1:0] sticky_q, sticky_d;
  logic valid_q, valid_d, ovfl_q, ovfl_d;
  logic [LGNCH-1:0] chan_q, chan_d;
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] cur, b, sat, nxt;
  logic [W:0] ea, eb, r;
  logic arith, up, ovf;
  always_comb begin
    cur = acc_q[i_chan];
    arith = i_op[2];
    up = ~i_op[0];
    b = i_op[1] ? W'(1) : i_val;
    ea = {OPT_SIGNED != 0 && cur[W-1], cur};
    eb = {OPT_SIGNED != 0 && b[W-1], b};
    r = up ? ea + eb : ea - eb;
    ovf = arith && (OPT_SIGNED != 0 ? r[W] ^ r[W-1] : r[W]);
    sat = OPT_SIGNED != 0 ? {r[W], {(W-1){~r[W]}}} : {W{up}};
    nxt = arith ? ((ovf && OPT_SATURATE != 0) ? sat : r[W-1:0]) :
          i_op == 3'd0 ? cur :
          i_op == 3'd1 ? '0 :
          i_op == 3'd2 ? '1 : i_val;
    acc_d = acc_q;
    sticky_d = sticky_q;
    if (i_stb) begin
      acc_d[i_chan] = nxt;
      sticky_d[i_chan] = i_op != 3'd1 && i_op != 3'd3 && (sticky_q[i_chan] || ovf);
    end
    valid_d = i_stb;
    chan_d = i_stb ? i_chan : chan_q;
    res_d = i_stb ? nxt : res_q;
    ovfl_d = i_stb ? ovf : ovfl_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q <= '{default: '0};
      sticky_q <= '0;
      valid_q <= 1'b0;
      chan_q <= '0;
      res_q <= '0;
      ovfl_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sticky_q <= sticky_d;
      valid_q <= valid_d;
      chan_q <= chan_d;
      res_q <= res_d;
      ovfl_q <= ovfl_d;
    end
  end
  assign o_valid = valid_q;
  assign o_chan = chan_q;
  assign o_acc = res_q;
  assign o_ovfl = ovfl_q;
  assign o_sticky = sticky_q;
endmodule

// File: tb/tb_sat_accum.sv
// tb_sat_accum: checks saturating, wrapping and signed sat_accum variants against a range model and vector table
module tb_sat_accum;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, stb = 1'b0;
  logic [1:0] ch = '0;
  logic [2:0] op = '0;
  logic [7:0] val = '0;
  logic [2:0] ovv, oo;
  logic [2:0][1:0] oc;
  logic [2:0][7:0] oa;
  logic [2:0][3:0] os;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sat_accum #(.W(8), .LGNCH(2), .OPT_SATURATE(g == 1 ? 0 : 1), .OPT_SIGNED(g == 2 ? 1 : 0)) u (
      .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_chan(ch), .i_op(op), .i_val(val),
      .o_valid(ovv[g]), .o_chan(oc[g]), .o_acc(oa[g]), .o_ovfl(oo[g]), .o_sticky(os[g])
    );
  end
  typedef struct packed {
    logic [1:0] ch;
    logic [2:0][7:0] acc;
    logic [2:0] ov;
  } exp_t;
  typedef struct {
    bit rst;
    bit stb;
    logic [1:0] ch;
    logic [2:0] op;
    logic [7:0] val;
    int d;
    logic [7:0] ea;
    bit eo;
  } vec_t;
  exp_t q[$];
  exp_t hold;
  logic [7:0] m_acc [3][4];
  logic [3:0] m_st [3];
  int errs = 0, checks = 0;
  vec_t vt[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  task automatic model(input int k, input logic [1:0] c, input logic [2:0] o, input logic [7:0] v,
                       output logic [7:0] res, output logic ov);
    longint a, b, t, lo, hi;
    bit sat, sgn;
    sat = k != 1;
    sgn = k == 2;
    a = sgn ? longint'($signed(m_acc[k][c])) : longint'(m_acc[k][c]);
    b = o[1] ? 1 : (sgn ? longint'($signed(v)) : longint'(v));
    lo = sgn ? -128 : 0;
    hi = sgn ? 127 : 255;
    ov = 1'b0;
    res = m_acc[k][c];
    case (o)
      3'd1: begin res = 8'h00; m_st[k][c] = 1'b0; end
      3'd2: res = 8'hff;
      3'd3: begin res = v; m_st[k][c] = 1'b0; end
      3'd4, 3'd5, 3'd6, 3'd7: begin
        t = o[0] ? a - b : a + b;
        ov = t < lo || t > hi;
        if (ov && sat) t = t > hi ? hi : lo;
        res = t[7:0];
        if (ov) m_st[k][c] = 1'b1;
      end
      default: ;
    endcase
    m_acc[k][c] = res;
  endtask
  task automatic step(input bit r_i, input bit s_i, input logic [1:0] c_i, input logic [2:0] o_i, input logic [7:0] v_i);
    exp_t e;
    @(negedge clk);
    rst = r_i;
    stb = s_i;
    ch = c_i;
    op = o_i;
    val = v_i;
    if (r_i) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 4; c++) m_acc[k][c] = 8'h00;
        m_st[k] = 4'h0;
      end
      hold = '0;
      q.delete();
    end else if (s_i) begin
      e.ch = c_i;
      for (int k = 0; k < 3; k++) model(k, c_i, o_i, v_i, e.acc[k], e.ov[k]);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      hold = q.pop_front();
      for (int k = 0; k < 3; k++) chk($sformatf("valid[%0d]", k), 32'(ovv[k]), 32'd1);
    end else begin
      for (int k = 0; k < 3; k++) chk($sformatf("valid[%0d]", k), 32'(ovv[k]), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("chan[%0d]", k), 32'(oc[k]), 32'(hold.ch));
      chk($sformatf("acc[%0d]", k), 32'(oa[k]), 32'(hold.acc[k]));
      chk($sformatf("ovfl[%0d]", k), 32'(oo[k]), 32'(hold.ov[k]));
      chk($sformatf("sticky[%0d]", k), 32'(os[k]), 32'(m_st[k]));
    end
  endtask
  function automatic vec_t mk(bit r, bit s, logic [1:0] c, logic [2:0] o, logic [7:0] v, int d, logic [7:0] ea, bit eo);
    vec_t x;
    x.rst = r; x.stb = s; x.ch = c; x.op = o; x.val = v; x.d = d; x.ea = ea; x.eo = eo;
    return x;
  endfunction
  initial begin
    vt.push_back(mk(1, 0, 0, 0, 0, -1, 0, 0));
    vt.push_back(mk(1, 1, 2, 4, 9, 0, 8'd0, 0));
    vt.push_back(mk(0, 1, 1, 3, 250, 0, 8'd250, 0));
    vt.push_back(mk(0, 1, 1, 4, 10, 0, 8'd255, 1));
    vt.push_back(mk(0, 1, 1, 7, 0, 0, 8'd254, 0));
    vt.push_back(mk(0, 1, 0, 1, 0, 1, 8'd0, 0));
    vt.push_back(mk(0, 1, 0, 7, 0, 1, 8'd255, 1));
    vt.push_back(mk(0, 1, 0, 6, 0, 1, 8'd0, 1));
    vt.push_back(mk(0, 1, 2, 3, 8'h7e, 2, 8'h7e, 0));
    vt.push_back(mk(0, 1, 2, 4, 5, 2, 8'h7f, 1));
    vt.push_back(mk(0, 1, 2, 3, 8'h81, 2, 8'h81, 0));
    vt.push_back(mk(0, 1, 2, 5, 3, 2, 8'h80, 1));
    vt.push_back(mk(0, 1, 2, 2, 0, 2, 8'hff, 0));
    vt.push_back(mk(0, 1, 2, 6, 0, 2, 8'h00, 0));
    vt.push_back(mk(0, 1, 2, 6, 0, 0, 8'hff, 1));
    vt.push_back(mk(0, 1, 3, 6, 0, 1, 8'd1, 0));
    vt.push_back(mk(0, 1, 3, 6, 0, 1, 8'd2, 0));
    vt.push_back(mk(0, 1, 3, 6, 0, 1, 8'd3, 0));
    vt.push_back(mk(0, 1, 3, 6, 0, 1, 8'd4, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 1, 8'd0, 0));
    vt.push_back(mk(0, 0, 1, 4, 99, 1, 8'd0, 0));
    vt.push_back(mk(0, 0, 2, 1, 0, 1, 8'd0, 0));
    vt.push_back(mk(0, 0, 3, 7, 0, 1, 8'd0, 0));
    vt.push_back(mk(0, 1, 1, 4, 7, 0, 8'd255, 1));
    vt.push_back(mk(1, 1, 1, 4, 7, 0, 8'd0, 0));
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 8'd0, 0));
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].rst, vt[i].stb, vt[i].ch, vt[i].op, vt[i].val);
      if (vt[i].d >= 0) begin
        chk($sformatf("vec%0d acc", i), 32'(oa[vt[i].d]), 32'(vt[i].ea));
        chk($sformatf("vec%0d ovfl", i), 32'(oo[vt[i].d]), 32'(vt[i].eo));
      end
    end
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
